// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating an instruction-fetch port and a load/store
// port onto a single 8-bit synchronous RAM; reads assemble little-endian into rdata.
module mem_ctrl #(
    parameter int MAX_LEN = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_re,
    input  logic [31:0] if_addr,
    input  logic [2:0]  if_len,
    output logic        if_done,
    input  logic        ls_re,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [2:0]  ls_len,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] rdata,
    output logic        busy,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  k_q, k_d;
    logic        iss_q, iss_d;
    logic [31:0] a_q, a_d;
    logic [2:0]  n_q, n_d;
    logic [31:0] wd_q, wd_d;
    logic        port_q, port_d;
    logic [31:0] rdata_q, rdata_d;

    assign rdata     = rdata_q;
    assign dbg_state = state_q;

    function automatic logic [2:0] eff_len(input logic [2:0] len);
        if (len == 3'd0 || int'(len) > MAX_LEN) return 3'(MAX_LEN);
        return len;
    endfunction

    // Handshake: a requester raises its level request only while busy=0 and holds it
    // until its one-cycle done pulse; the request is taken at the end of an IDLE or DONE
    // cycle with rdy_in=1, and dropping it afterwards does not cancel the transfer.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        iss_d    = iss_q;
        a_d      = a_q;
        n_d      = n_q;
        wd_d     = wd_q;
        port_d   = port_q;
        rdata_d  = rdata_q;
        mem_a    = '0;
        mem_wr   = 1'b0;
        mem_dout = '0;
        busy     = 1'b0;
        if_done  = 1'b0;
        ls_done  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) begin
                    if_done = ~port_q;
                    ls_done = port_q;
                end
                state_d = S_IDLE;
                if (rdy_in && (ls_we || ls_re || if_re)) begin
                    k_d   = 3'd0;
                    iss_d = 1'b0;
                    wd_d  = ls_wdata;
                    if (ls_we || ls_re) begin
                        port_d  = 1'b1;
                        a_d     = ls_addr;
                        n_d     = eff_len(ls_len);
                        state_d = ls_we ? S_WRITE : S_READ;
                    end else begin
                        port_d  = 1'b0;
                        a_d     = if_addr;
                        n_d     = eff_len(if_len);
                        state_d = S_READ;
                    end
                end
            end

            S_READ: begin
                busy = 1'b1;
                // iss_q marks that mem_din this cycle carries byte k_q.
                if (!rdy_in) begin
                    mem_a = a_q + 32'(k_q);
                end else begin
                    mem_a = a_q + 32'(k_q) + 32'(iss_q);
                    iss_d = 1'b1;
                    if (iss_q) begin
                        if (k_q == 3'd0) begin
                            rdata_d = {24'd0, mem_din};
                        end else if (k_q < 3'd4) begin
                            rdata_d[{k_q[1:0], 3'b000} +: 8] = mem_din;
                        end
                        k_d = k_q + 3'd1;
                        if (k_q + 3'd1 == n_q) state_d = S_DONE;
                    end
                end
            end

            S_WRITE: begin
                busy  = 1'b1;
                mem_a = a_q + 32'(k_q);
                if (k_q < 3'd4) mem_dout = wd_q[{k_q[1:0], 3'b000} +: 8];
                if (rdy_in) begin
                    mem_wr = 1'b1;
                    k_d    = k_q + 3'd1;
                    if (k_q + 3'd1 == n_q) state_d = S_DONE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            k_q     <= 3'd0;
            iss_q   <= 1'b0;
            a_q     <= '0;
            n_q     <= 3'd0;
            wd_q    <= '0;
            port_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            iss_q   <= iss_d;
            a_q     <= a_d;
            n_q     <= n_d;
            wd_q    <= wd_d;
            port_q  <= port_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed literal scenarios plus randomized traffic, all checked
// every cycle against a transaction-level model of the two-port byte-serial controller.
module tb_mem_ctrl;
    localparam int MAX_LEN = 4;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        if_re = 1'b0;
    logic [31:0] if_addr = '0;
    logic [2:0]  if_len = '0;
    logic        if_done;
    logic        ls_re = 1'b0;
    logic        ls_we = 1'b0;
    logic [31:0] ls_addr = '0;
    logic [2:0]  ls_len = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_done;
    logic [31:0] rdata;
    logic        busy;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    mem_ctrl #(.MAX_LEN(MAX_LEN)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_re(if_re), .if_addr(if_addr), .if_len(if_len), .if_done(if_done),
        .ls_re(ls_re), .ls_we(ls_we), .ls_addr(ls_addr), .ls_len(ls_len),
        .ls_wdata(ls_wdata), .ls_done(ls_done),
        .rdata(rdata), .busy(busy),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .dbg_state(dbg_state)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // RAM environment and the model's own copy of memory
    logic [7:0] ram [logic [31:0]];
    logic [7:0] mdl_mem [logic [31:0]];

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
    endfunction
    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : dflt(a);
    endfunction
    function automatic logic [7:0] mdl_rd(input logic [31:0] a);
        return mdl_mem.exists(a) ? mdl_mem[a] : dflt(a);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        ram[a] = d;
        mdl_mem[a] = d;
    endtask

    always @(posedge clk_in) begin
        mem_din <= ram_rd(mem_a);
        if (mem_wr) ram[mem_a] = mem_dout;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: one step per ready cycle, N+1 steps for a read, N for a write
    logic        m_act = 1'b0;
    logic        m_wr = 1'b0;
    int          m_port = 0;
    int          m_done = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata = '0;
    int          m_n = 0;
    int          m_steps = 0;

    always @(posedge clk_in) begin
        if (!rst_in) begin
            m_act = 1'b0;
            m_done = 0;
            m_rdata = '0;
        end else if (m_act) begin
            m_done = 0;
            if (rdy_in) begin
                if (m_wr) begin
                    mdl_mem[m_addr + 32'(m_steps)] = 8'(m_wdata >> (8 * m_steps));
                    m_steps++;
                    if (m_steps == m_n) begin
                        m_act = 1'b0;
                        m_done = m_port;
                    end
                end else begin
                    m_steps++;
                    if (m_steps == m_n + 1) begin
                        m_rdata = '0;
                        for (int i = 0; i < m_n; i++)
                            m_rdata = m_rdata | (32'(mdl_rd(m_addr + 32'(i))) << (8 * i));
                        m_act = 1'b0;
                        m_done = m_port;
                    end
                end
            end
        end else begin
            m_done = 0;
            if (rdy_in && (ls_we || ls_re || if_re)) begin
                m_act = 1'b1;
                m_steps = 0;
                if (ls_we || ls_re) begin
                    m_port = 2;
                    m_wr = ls_we;
                    m_addr = ls_addr;
                    m_wdata = ls_wdata;
                    m_n = int'(ls_len);
                end else begin
                    m_port = 1;
                    m_wr = 1'b0;
                    m_addr = if_addr;
                    m_n = int'(if_len);
                end
                if (m_n == 0 || m_n > MAX_LEN) m_n = MAX_LEN;
            end
        end
    end

    always @(negedge clk_in) begin
        chk("busy", busy, m_act);
        chk("if_done", if_done, m_done == 1);
        chk("ls_done", ls_done, m_done == 2);
        if (!m_act) begin
            chk("mem_wr_idle", mem_wr, 1'b0);
            chk("rdata", rdata, m_rdata);
            if (m_done == 0) begin
                chk("mem_a_idle", mem_a, 32'h0);
                chk("mem_dout_idle", mem_dout, 32'h0);
            end
        end else if (m_wr) begin
            chk("rdata_hold_wr", rdata, m_rdata);
            chk("mem_a_wr", mem_a, m_addr + 32'(m_steps));
            if (rdy_in) begin
                chk("mem_wr_wr", mem_wr, 1'b1);
                chk("mem_dout_wr", mem_dout, 32'(8'(m_wdata >> (8 * m_steps))));
            end else begin
                chk("mem_wr_frz", mem_wr, 1'b0);
            end
        end else begin
            chk("mem_wr_rd", mem_wr, 1'b0);
            if (!rdy_in)
                chk("mem_a_rd_frz", mem_a, m_addr + 32'((m_steps == 0) ? 0 : m_steps - 1));
            else if (m_steps < m_n)
                chk("mem_a_rd", mem_a, m_addr + 32'(m_steps));
        end
    end

    // Called at the negedge of cycle c_start; returns the cycle index where done is seen
    task automatic wait_done(input int c_start, input bit ls, output int c_at);
        int c;
        c = c_start;
        while (c < 40 && !(ls ? ls_done : if_done)) begin
            @(negedge clk_in);
            c++;
        end
        c_at = c;
    endtask

    task automatic drop_all();
        #1;
        if_re = 1'b0;
        ls_re = 1'b0;
        ls_we = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        return 32'($urandom_range(0, 255));
    endfunction

    initial begin
        int c;
        logic [31:0] exp_a [4];

        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", mem_wr, 1'b0);
        chk("rst_done", {if_done, ls_done}, 32'h0);
        @(posedge clk_in); #2;
        rst_in = 1'b1;

        // Instruction fetch read of four bytes
        preload(32'h100, 8'h13); preload(32'h101, 8'h00);
        preload(32'h102, 8'h00); preload(32'h103, 8'h93);
        @(posedge clk_in); #2;
        if_re = 1'b1; if_addr = 32'h100; if_len = 3'd4;
        @(negedge clk_in);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            chk("t1_mem_a", mem_a, 32'h100 + 32'(k));
        end
        wait_done(4, 1'b0, c);
        chk("t1_done_cycle", c, 6);
        chk("t1_rdata", rdata, 32'h9300_0013);
        drop_all();

        // Two-byte store
        @(posedge clk_in); #2;
        ls_we = 1'b1; ls_addr = 32'h20; ls_len = 3'd2; ls_wdata = 32'hAABB_CCDD;
        @(negedge clk_in);
        @(negedge clk_in);
        chk("t2_c1_wr", mem_wr, 1'b1); chk("t2_c1_a", mem_a, 32'h20); chk("t2_c1_d", mem_dout, 32'hDD);
        @(negedge clk_in);
        chk("t2_c2_wr", mem_wr, 1'b1); chk("t2_c2_a", mem_a, 32'h21); chk("t2_c2_d", mem_dout, 32'hCC);
        @(negedge clk_in);
        chk("t2_ls_done", ls_done, 1'b1);
        chk("t2_if_done", if_done, 1'b0);
        drop_all();

        // Contention: load/store port first, fetch follows with no idle cycle
        preload(32'h40, 8'h7F); preload(32'h200, 8'h5C);
        @(posedge clk_in); #2;
        if_re = 1'b1; if_addr = 32'h200; if_len = 3'd1;
        ls_re = 1'b1; ls_addr = 32'h40; ls_len = 3'd1;
        @(negedge clk_in);
        wait_done(0, 1'b1, c);
        chk("t3_ls_cycle", c, 3);
        chk("t3_if_quiet", if_done, 1'b0);
        chk("t3_ls_rdata", rdata, 32'h0000_007F);
        #1 ls_re = 1'b0;
        @(negedge clk_in);
        chk("t3_no_bubble", busy, 1'b1);
        wait_done(4, 1'b0, c);
        chk("t3_if_cycle", c, 6);
        chk("t3_if_rdata", rdata, 32'h0000_005C);
        drop_all();

        // Freeze for three cycles after C2 of a four-byte read
        preload(32'h300, 8'h11); preload(32'h301, 8'h22);
        preload(32'h302, 8'h33); preload(32'h303, 8'h44);
        @(posedge clk_in); #2;
        if_re = 1'b1; if_addr = 32'h300; if_len = 3'd4;
        repeat (3) @(negedge clk_in);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in); #2 rdy_in = 1'b0;
            @(negedge clk_in);
            chk("t4_frz_wr", mem_wr, 1'b0);
            chk("t4_frz_a", mem_a, 32'h301);
        end
        @(posedge clk_in); #2 rdy_in = 1'b1;
        @(negedge clk_in);
        wait_done(6, 1'b0, c);
        chk("t4_done_cycle", c, 9);
        chk("t4_rdata", rdata, 32'h4433_2211);
        drop_all();

        // Address wrap with len=0 meaning four bytes
        preload(32'hFFFF_FFFE, 8'h01); preload(32'hFFFF_FFFF, 8'h02);
        preload(32'h0000_0000, 8'h03); preload(32'h0000_0001, 8'h04);
        exp_a[0] = 32'hFFFF_FFFE; exp_a[1] = 32'hFFFF_FFFF;
        exp_a[2] = 32'h0000_0000; exp_a[3] = 32'h0000_0001;
        @(posedge clk_in); #2;
        if_re = 1'b1; if_addr = 32'hFFFF_FFFE; if_len = 3'd0;
        @(negedge clk_in);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            chk("t5_mem_a", mem_a, exp_a[k]);
        end
        wait_done(4, 1'b0, c);
        chk("t5_done_cycle", c, 6);
        chk("t5_rdata", rdata, 32'h0403_0201);
        drop_all();

        // Reset during C3 of a four-byte write
        @(posedge clk_in); #2;
        ls_we = 1'b1; ls_addr = 32'h500; ls_len = 3'd4; ls_wdata = 32'h0102_0304;
        repeat (3) @(negedge clk_in);
        @(posedge clk_in); #2 rst_in = 1'b0;
        @(negedge clk_in);
        chk("t6_c3_wr", mem_wr, 1'b1);
        @(posedge clk_in); #2;
        rst_in = 1'b1; ls_we = 1'b0;
        if_re = 1'b1; if_addr = 32'h100; if_len = 3'd4;
        @(negedge clk_in);
        chk("t6_wr_off", mem_wr, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_no_done", ls_done, 1'b0);
        chk("t6_rdata_clr", rdata, 32'h0);
        @(negedge clk_in);
        chk("t6_accept", busy, 1'b1);
        wait_done(5, 1'b0, c);
        chk("t6_done_cycle", c, 10);
        chk("t6_rdata", rdata, 32'h9300_0013);
        chk("t6_ram_502", ram_rd(32'h502), 32'h02);
        chk("t6_ram_503", ram_rd(32'h503), 32'(dflt(32'h503)));
        drop_all();

        // Randomized traffic
        for (int cy = 0; cy < 3000; cy++) begin
            @(posedge clk_in); #2;
            if (if_done) if_re = 1'b0;
            if (ls_done) begin
                ls_re = 1'b0;
                ls_we = 1'b0;
            end
            rdy_in = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 199) == 0) begin
                rst_in = 1'b0;
                if_re = 1'b0; ls_re = 1'b0; ls_we = 1'b0;
            end else begin
                rst_in = 1'b1;
                if (!busy) begin
                    if (!if_re && $urandom_range(0, 3) == 0) begin
                        if_re = 1'b1;
                        if_addr = rand_addr();
                        if_len = 3'($urandom_range(0, 7));
                    end
                    if (!ls_re && !ls_we && $urandom_range(0, 3) == 0) begin
                        case ($urandom_range(0, 2))
                            0: ls_re = 1'b1;
                            1: ls_we = 1'b1;
                            default: begin ls_re = 1'b1; ls_we = 1'b1; end
                        endcase
                        ls_addr = rand_addr();
                        ls_len = 3'($urandom_range(0, 7));
                        ls_wdata = $urandom;
                    end
                end else if ($urandom_range(0, 49) == 0) begin
                    if ($urandom_range(0, 1) == 0) if_re = 1'b0;
                    else begin ls_re = 1'b0; ls_we = 1'b0; end
                end
            end
        end
        @(posedge clk_in); #2;
        rdy_in = 1'b1; rst_in = 1'b1;
        if_re = 1'b0; ls_re = 1'b0; ls_we = 1'b0;
        repeat (12) @(posedge clk_in);
        @(negedge clk_in);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter: MAX_LEN, 4, largest transfer in bytes; req lengths above it are clipped to it.
REQ-002 clk_in  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_in  in  1  reset, synchronous, active-low.
REQ-004 rdy_in  in  1  global ready; 0 = freeze (see REQ-021).
REQ-005 if_re  in  1  port-1 (instruction fetch) read request, level, held until if_done.
REQ-006 if_addr  in  32  port-1 byte address.
REQ-007 if_len  in  3  port-1 length in bytes.
REQ-008 if_done  out  1  port-1 completion pulse, one cycle.
REQ-009 ls_re, ls_we  in  1 each  port-2 (load/store) read/write request, level, held until ls_done.
REQ-010 ls_addr  in  32; ls_len  in  3; ls_wdata  in  32  port-2 address, length, store data.
REQ-011 ls_done  out  1  port-2 completion pulse, one cycle.
REQ-012 rdata  out  32  read result, shared by both ports, little-endian, unused upper bytes zero.
REQ-013 busy  out  1  transaction in progress; requesters only raise new requests while 0.
REQ-014 mem_din  in  8  RAM read byte, valid the cycle after its address.
REQ-015 mem_dout  out  8; mem_a  out  32; mem_wr  out  1  RAM write data, byte address, write strobe (1 = write).

Function
REQ-016 States: IDLE, READ, WRITE, DONE; a 3-bit byte counter k and a latched copy of addr, len, wdata, port.
REQ-017 Accept: in IDLE with rdy_in=1, a request sampled at the end of cycle C0 is latched; port 2 beats port 1 when both request; on port 2, ls_we beats ls_re.
REQ-018 Effective length N = len if 1 <= len <= MAX_LEN, else MAX_LEN (len=0 -> MAX_LEN).
REQ-019 Read: cycle C(1+k) drives mem_a=addr+k, mem_wr=0 for k=0..N-1; byte k taken from mem_din in cycle C(2+k) into rdata[8k+7:8k]; DONE in C(N+2) with port done=1 and rdata valid.
REQ-020 Write: cycle C(1+k) drives mem_a=addr+k, mem_dout=wdata[8k+7:8k], mem_wr=1; DONE in C(N+1) with port done=1; rdata unchanged.
REQ-021 rdy_in=0: FSM, counter, and latches hold; mem_wr=0; mem_a = address of the oldest not-yet-captured byte (read) or the next byte to write; on resume no byte is lost or duplicated.
REQ-022 busy=1 from C1 through the cycle before DONE; busy=0 in DONE, so a new request can be accepted at the end of the DONE cycle (zero-bubble back-to-back).
REQ-023 done pulses exactly one cycle, only for the latched port; the other port's done stays 0.
REQ-024 rdata holds its value until the next read writes byte 0; bytes k >= N of a read are 0.
REQ-025 Address arithmetic is 32-bit modulo; addr+k wraps 0xFFFFFFFF -> 0x00000000.
REQ-026 A request deasserted mid-transaction is ignored; the transaction completes.
REQ-027 mem_wr is never 1 outside WRITE, nor in a cycle with rdy_in=0.
REQ-028 In IDLE: mem_a=0, mem_wr=0, mem_dout=0, busy=0.

Reset
REQ-029 rst_in=0 at a clock edge forces IDLE, k=0, busy=0, if_done=0, ls_done=0, rdata=0, mem_a=0, mem_dout=0, mem_wr=0; this takes precedence over rdy_in.
REQ-030 Reset mid-transaction aborts it with no done pulse; RAM writes already issued are not undone.

Verification
REQ-031 IF read: if_re=1, if_addr=0x100, if_len=4, RAM[0x100..0x103]=13,00,00,93 -> mem_a 0x100..0x103 in C1..C4, if_done=1 in C6, rdata=0x93000013.
REQ-032 Store: ls_we=1, ls_addr=0x20, ls_len=2, ls_wdata=0xAABBCCDD -> mem_wr=1 in C1..C2 with (0x20,DD), (0x21,CC); ls_done=1 in C3; no if_done.
REQ-033 Contention: if_re and ls_re raised in the same cycle (ls_len=1, RAM[0x40]=0x7F) -> port 2 served first (ls_done, rdata=0x0000007F), then port 1 served back-to-back with no idle cycle.
REQ-034 Freeze: 4-byte read with rdy_in=0 for 3 cycles after C2 -> mem_wr=0 throughout, if_done delayed by exactly 3 cycles, rdata correct.
REQ-035 Boundaries: read at 0xFFFFFFFE, len=4 -> mem_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001; len=0 -> 4 bytes.
REQ-036 Reset at C3 of a 4-byte write -> mem_wr=0 next cycle, no ls_done, busy=0, IDLE accepts a new request next cycle.
